// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the peripheral-side master and apb_slave_regfile.
// PSTRB exists only when APB_SLAVE_PSTRB_EN is defined.
interface apb_slave_regfile_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
`ifdef APB_SLAVE_PSTRB_EN
    logic [3:0]  PSTRB;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );
    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
`else
    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );
    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
`endif
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer with a word-addressed register file and programmable wait states.
// Register 0 is a read-only ID; registers 1..NUM_REGS-1 are read/write and exported flat.
// Optional byte strobes: define APB_SLAVE_PSTRB_EN.
module apb_slave_regfile #(
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    apb_slave_regfile_if.slave        apb,
    output logic [NUM_REGS*32-1:0]    regs_o
);

    localparam int unsigned IdxW      = $clog2(NUM_REGS);
    localparam logic [31:0] AddrLimit = 32'(NUM_REGS * 4);
    localparam logic [3:0]  WaitCnt   = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e          state_q;
    logic [3:0]      cnt_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic            write_q;
    logic            err_q;
    logic            pready_q;
    logic            pslverr_q;
    logic [31:0]     prdata_q;
`ifdef APB_SLAVE_PSTRB_EN
    logic [3:0]      strb_q;
`endif

    logic [31:0]     regs_q    [1:NUM_REGS-1];
    logic [31:0]     regs_view [NUM_REGS];

    logic [31:0]     dec_addr;
    logic            dec_write;
    logic [IdxW-1:0] dec_idx;
    logic            dec_err;
    logic [31:0]     rd_resp;
    logic [IdxW-1:0] wr_idx;
    logic            commit;

    // Register 0 reads as the ID constant; the rest come from storage.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_view
        if (i == 0) begin : g_id
            assign regs_view[i] = ID_VALUE;
        end else begin : g_reg
            assign regs_view[i] = regs_q[i];
        end
        assign regs_o[32*i +: 32] = regs_view[i];
    end

    // Decode the live bus in IDLE (needed when there are no wait states), else the latched request.
    always_comb begin
        if (state_q == StIdle) begin
            dec_addr  = apb.PADDR;
            dec_write = apb.PWRITE;
        end else begin
            dec_addr  = addr_q;
            dec_write = write_q;
        end
    end

    assign dec_idx = dec_addr[2 +: IdxW];
    assign dec_err = (dec_addr[1:0] != 2'b00) || (dec_addr >= AddrLimit) ||
                     (dec_write && (dec_idx == '0));
    assign rd_resp = dec_err ? 32'h0 : regs_view[dec_idx];

    // A DONE cycle aborted by PSEL=0 must not write.
    assign wr_idx = addr_q[2 +: IdxW];
    assign commit = (state_q == StDone) && apb.PSEL && write_q && !err_q;

    // Transfer sequencing: latch in SETUP, count wait states, answer for one cycle in DONE.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
`ifdef APB_SLAVE_PSTRB_EN
            strb_q    <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    if (apb.PSEL && !apb.PENABLE) begin
                        addr_q  <= apb.PADDR;
                        write_q <= apb.PWRITE;
                        wdata_q <= apb.PWDATA;
                        err_q   <= dec_err;
                        cnt_q   <= WaitCnt;
`ifdef APB_SLAVE_PSTRB_EN
                        strb_q  <= apb.PSTRB;
`endif
                        if (WAIT_CYCLES == 0) begin
                            state_q   <= StDone;
                            pready_q  <= 1'b1;
                            pslverr_q <= dec_err;
                            if (!dec_write) begin
                                prdata_q <= rd_resp;
                            end
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (!apb.PSEL) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q <= 4'd1) begin
                            state_q   <= StDone;
                            pready_q  <= 1'b1;
                            pslverr_q <= dec_err;
                            if (!dec_write) begin
                                prdata_q <= rd_resp;
                            end
                        end
                    end
                end
                StDone: begin
                    state_q   <= StIdle;
                    cnt_q     <= '0;
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                end
                default: begin
                    state_q   <= StIdle;
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                end
            endcase
        end
    end

    // Register storage: commit on the edge that closes DONE.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_idx == IdxW'(i)) begin
`ifdef APB_SLAVE_PSTRB_EN
                    for (int b = 0; b < 4; b++) begin
                        if (strb_q[b]) begin
                            regs_q[i][8*b +: 8] <= wdata_q[8*b +: 8];
                        end
                    end
`else
                    regs_q[i] <= wdata_q;
`endif
                end
            end
        end
    end

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances (WAIT_CYCLES = 1, 0, 3) share one driven bus,
// PSEL steers the transfer to the selected instance. A reference model predicts each response.
module tb_apb_slave_regfile;

    localparam logic [31:0] Id = 32'hA5B0_0001;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } req_t;

    typedef struct packed {
        logic [7:0]  lat;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    typedef struct packed {
        logic [255:0] at_rdy;
        logic [255:0] after;
    } snap_t;

    logic        clk;
    logic        rst_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
`ifdef APB_SLAVE_PSTRB_EN
    logic [3:0]  pstrb;
`endif
    int          dut_sel;
    int          cyc;
    int          total;
    int          bad;

    logic [31:0]  prdata_a  [3];
    logic         pready_a  [3];
    logic         pslverr_a [3];
    logic [255:0] regs_a    [3];
    logic [31:0]  prdata_m;
    logic         pready_m;
    logic         pslverr_m;
    logic [255:0] regs_m;

    logic [31:0] mdl     [3][8];
    logic [31:0] last_rd [3];

    resp_t exp_r[$];
    resp_t obs_r[$];
    snap_t exp_s[$];
    snap_t obs_s[$];

    for (genvar k = 0; k < 3; k++) begin : g_dut
        apb_slave_regfile_if bus ();
        logic [255:0] regs;

        assign bus.PSEL    = psel && (dut_sel == k);
        assign bus.PENABLE = penable;
        assign bus.PWRITE  = pwrite;
        assign bus.PADDR   = paddr;
        assign bus.PWDATA  = pwdata;
`ifdef APB_SLAVE_PSTRB_EN
        assign bus.PSTRB   = pstrb;
`endif
        assign prdata_a[k]  = bus.PRDATA;
        assign pready_a[k]  = bus.PREADY;
        assign pslverr_a[k] = bus.PSLVERR;
        assign regs_a[k]    = regs;

        apb_slave_regfile #(
            .NUM_REGS    (8),
            .WAIT_CYCLES ((k == 0) ? 1 : ((k == 1) ? 0 : 3)),
            .ID_VALUE    (Id)
        ) u_dut (
            .PCLK    (clk),
            .PRESETn (rst_n),
            .apb     (bus),
            .regs_o  (regs)
        );
    end

    always_comb begin
        prdata_m  = prdata_a[dut_sel];
        pready_m  = pready_a[dut_sel];
        pslverr_m = pslverr_a[dut_sel];
        regs_m    = regs_a[dut_sel];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    function automatic int wait_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    function automatic logic [255:0] pack(input int k);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) begin
            v[32*i +: 32] = (i == 0) ? Id : mdl[k][i];
        end
        return v;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 3; k++) begin
            last_rd[k] = 32'h0;
            for (int i = 0; i < 8; i++) mdl[k][i] = 32'h0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_model();
    endtask

    // Drive one complete transfer starting at posedge+1; ends at posedge+1 after DONE.
    task automatic apb_xfer(input req_t r, output resp_t o, output snap_t s);
        int n;
        o.lat   = 8'hFF;
        o.err   = 1'bx;
        o.rdata = 'x;
        s.at_rdy = 'x;
        psel = 1'b1; penable = 1'b0; pwrite = r.wr; paddr = r.addr; pwdata = r.data;
`ifdef APB_SLAVE_PSTRB_EN
        pstrb = r.strb;
`endif
        @(posedge clk); #1;
        penable = 1'b1;
        n = 1;
        while (n <= 20) begin
            @(negedge clk);
            if (pready_m) begin
                o.lat    = 8'(n);
                o.err    = pslverr_m;
                o.rdata  = prdata_m;
                s.at_rdy = regs_m;
                break;
            end
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        s.after = regs_m;
        psel = 1'b0; penable = 1'b0;
    endtask

    // Predict, push expectation, drive, push observation.
    task automatic issue(input int k, input req_t r);
        resp_t er, ob;
        snap_t es, os;
        int    idx;
        logic  err;
        logic [3:0] strb_eff;
        idx = int'(r.addr[4:2]);
        err = (r.addr[1:0] != 2'b00) || (r.addr >= 32'd32) || (r.wr && idx == 0);
`ifdef APB_SLAVE_PSTRB_EN
        strb_eff = r.strb;
`else
        strb_eff = 4'hF;
`endif
        if (!r.wr) last_rd[k] = err ? 32'h0 : ((idx == 0) ? Id : mdl[k][idx]);
        er.lat   = 8'(wait_of(k) + 1);
        er.err   = err;
        er.rdata = last_rd[k];
        es.at_rdy = pack(k);
        if (r.wr && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (strb_eff[b]) mdl[k][idx][8*b +: 8] = r.data[8*b +: 8];
            end
        end
        es.after = pack(k);
        exp_r.push_back(er);
        exp_s.push_back(es);
        dut_sel = k;
        apb_xfer(r, ob, os);
        obs_r.push_back(ob);
        obs_s.push_back(os);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            dut_sel = k;
            #1;
            total++;
            if ({pready_m, pslverr_m, prdata_m} !== 34'h0) begin
                bad++;
                $display("FAIL reset outputs dut%0d: got ready=%b err=%b rdata=%h want 0/0/0",
                         k, pready_m, pslverr_m, prdata_m);
            end
            total++;
            if (regs_m !== pack(k)) begin
                bad++;
                $display("FAIL reset regs dut%0d: got %h want %h", k, regs_m, pack(k));
            end
        end
    endtask

    task automatic test_read_id();
        resp_t er, ob;
        snap_t es, os;
        issue(0, '{1'b0, 32'h0, 32'h0, 4'hF});
        issue(2, '{1'b0, 32'h0, 32'h0, 4'hF});
        while (exp_r.size() > 0) begin
            er = exp_r.pop_front(); ob = obs_r.pop_front();
            es = exp_s.pop_front(); os = obs_s.pop_front();
            total++;
            if (ob !== er) begin
                bad++;
                $display("FAIL read_id resp: got lat=%0d err=%b rdata=%h want lat=%0d err=%b rdata=%h",
                         ob.lat, ob.err, ob.rdata, er.lat, er.err, er.rdata);
            end
            total++;
            if (os !== es) begin
                bad++;
                $display("FAIL read_id regs: got %h/%h want %h/%h", os.at_rdy, os.after,
                         es.at_rdy, es.after);
            end
        end
    endtask

    task automatic test_write_read();
        resp_t er, ob;
        snap_t es, os;
        issue(0, '{1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF});
        issue(0, '{1'b0, 32'h4, 32'h0, 4'hF});
        issue(0, '{1'b1, 32'h1C, 32'hCAFE_0007, 4'hF});
        issue(0, '{1'b0, 32'h1C, 32'h0, 4'hF});
        issue(0, '{1'b0, 32'h4, 32'h0, 4'hF});
        while (exp_r.size() > 0) begin
            er = exp_r.pop_front(); ob = obs_r.pop_front();
            es = exp_s.pop_front(); os = obs_s.pop_front();
            total++;
            if (ob !== er) begin
                bad++;
                $display("FAIL write_read resp: got lat=%0d err=%b rdata=%h want lat=%0d err=%b rdata=%h",
                         ob.lat, ob.err, ob.rdata, er.lat, er.err, er.rdata);
            end
            total++;
            if (os !== es) begin
                bad++;
                $display("FAIL write_read regs: got %h/%h want %h/%h", os.at_rdy, os.after,
                         es.at_rdy, es.after);
            end
        end
    endtask

    task automatic test_errors();
        resp_t er, ob;
        snap_t es, os;
        req_t  tbl [5];
        tbl = '{'{1'b1, 32'h00, 32'h1234_5678, 4'hF},
                '{1'b1, 32'h02, 32'h1234_5678, 4'hF},
                '{1'b1, 32'h20, 32'h1234_5678, 4'hF},
                '{1'b0, 32'h20, 32'h0, 4'hF},
                '{1'b0, 32'h05, 32'h0, 4'hF}};
        foreach (tbl[i]) issue(0, tbl[i]);
        while (exp_r.size() > 0) begin
            er = exp_r.pop_front(); ob = obs_r.pop_front();
            es = exp_s.pop_front(); os = obs_s.pop_front();
            total++;
            if (ob !== er) begin
                bad++;
                $display("FAIL errors resp: got lat=%0d err=%b rdata=%h want lat=%0d err=%b rdata=%h",
                         ob.lat, ob.err, ob.rdata, er.lat, er.err, er.rdata);
            end
            total++;
            if (os !== es) begin
                bad++;
                $display("FAIL errors regs: got %h/%h want %h/%h", os.at_rdy, os.after,
                         es.at_rdy, es.after);
            end
        end
    endtask

    task automatic test_back_to_back();
        resp_t er, ob;
        snap_t es, os;
        int    c0;
        c0 = cyc;
        issue(1, '{1'b1, 32'h08, 32'h1, 4'hF});
        issue(1, '{1'b0, 32'h08, 32'h0, 4'hF});
        total++;
        if (cyc - c0 !== 4) begin
            bad++;
            $display("FAIL back_to_back cycles: got %0d want 4", cyc - c0);
        end
        while (exp_r.size() > 0) begin
            er = exp_r.pop_front(); ob = obs_r.pop_front();
            es = exp_s.pop_front(); os = obs_s.pop_front();
            total++;
            if (ob !== er) begin
                bad++;
                $display("FAIL back_to_back resp: got lat=%0d err=%b rdata=%h want lat=%0d err=%b rdata=%h",
                         ob.lat, ob.err, ob.rdata, er.lat, er.err, er.rdata);
            end
            total++;
            if (os !== es) begin
                bad++;
                $display("FAIL back_to_back regs: got %h/%h want %h/%h", os.at_rdy, os.after,
                         es.at_rdy, es.after);
            end
        end
    endtask

    task automatic test_abort_reset();
        resp_t er, ob;
        snap_t es, os;
        logic  seen;
        // Abort: PSEL dropped during the second WAIT cycle.
        dut_sel = 2;
        seen = 1'b0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        seen = seen | pready_m;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | pready_m;
            @(posedge clk); #1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL abort pready: got asserted=%b want 0", seen);
        end
        total++;
        if (regs_m !== pack(2)) begin
            bad++;
            $display("FAIL abort regs: got %h want %h", regs_m, pack(2));
        end
        issue(2, '{1'b0, 32'h0C, 32'h0, 4'hF});
        issue(2, '{1'b1, 32'h04, 32'h55AA_55AA, 4'hF});
        // Reset in the middle of a write to 0x10.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h1234_5678;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; psel = 1'b0; penable = 1'b0;
        clear_model();
        @(negedge clk);
        total++;
        if (pready_m !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid pready: got %b want 0", pready_m);
        end
        total++;
        if (regs_m !== pack(2)) begin
            bad++;
            $display("FAIL reset_mid regs: got %h want %h", regs_m, pack(2));
        end
        @(posedge clk); #1;
        issue(2, '{1'b0, 32'h10, 32'h0, 4'hF});
        issue(2, '{1'b0, 32'h04, 32'h0, 4'hF});
        while (exp_r.size() > 0) begin
            er = exp_r.pop_front(); ob = obs_r.pop_front();
            es = exp_s.pop_front(); os = obs_s.pop_front();
            total++;
            if (ob !== er) begin
                bad++;
                $display("FAIL abort_reset resp: got lat=%0d err=%b rdata=%h want lat=%0d err=%b rdata=%h",
                         ob.lat, ob.err, ob.rdata, er.lat, er.err, er.rdata);
            end
            total++;
            if (os !== es) begin
                bad++;
                $display("FAIL abort_reset regs: got %h/%h want %h/%h", os.at_rdy, os.after,
                         es.at_rdy, es.after);
            end
        end
    endtask

`ifdef APB_SLAVE_PSTRB_EN
    task automatic test_pstrb();
        resp_t er, ob;
        snap_t es, os;
        issue(0, '{1'b1, 32'h04, 32'h1111_1111, 4'hF});
        issue(0, '{1'b1, 32'h04, 32'hAABB_CCDD, 4'b0101});
        issue(0, '{1'b0, 32'h04, 32'h0, 4'h0});
        issue(0, '{1'b1, 32'h04, 32'h9999_9999, 4'b0000});
        issue(0, '{1'b0, 32'h04, 32'h0, 4'hF});
        total++;
        if (mdl[0][1] !== 32'h11BB_11DD) begin
            bad++;
            $display("FAIL pstrb model: got %h want 11bb11dd", mdl[0][1]);
        end
        while (exp_r.size() > 0) begin
            er = exp_r.pop_front(); ob = obs_r.pop_front();
            es = exp_s.pop_front(); os = obs_s.pop_front();
            total++;
            if (ob !== er) begin
                bad++;
                $display("FAIL pstrb resp: got lat=%0d err=%b rdata=%h want lat=%0d err=%b rdata=%h",
                         ob.lat, ob.err, ob.rdata, er.lat, er.err, er.rdata);
            end
            total++;
            if (os !== es) begin
                bad++;
                $display("FAIL pstrb regs: got %h/%h want %h/%h", os.at_rdy, os.after,
                         es.at_rdy, es.after);
            end
        end
    endtask
`endif

    initial begin
        total   = 0;
        bad     = 0;
        cyc     = 0;
        dut_sel = 0;
        rst_n   = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h0;
        pwdata  = 32'h0;
`ifdef APB_SLAVE_PSTRB_EN
        pstrb   = 4'hF;
`endif
        clear_model();
        do_reset();
        test_reset();
        test_read_id();
        test_write_read();
        test_errors();
        test_back_to_back();
        test_abort_reset();
`ifdef APB_SLAVE_PSTRB_EN
        test_pstrb();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
